// File: rtl/multdiv_wb_scheduler.sv
// rtl/multdiv_wb_scheduler.sv - mult/div issue sequencer and register-file write-port arbiter
//
// Purpose: issues start pulses to the shared mult/div unit from DX, tracks the
// in-flight (PW) instruction, stalls FD/DX on structural and RAW hazards against
// it, and shares the single register-file write port between MW and PW (MW wins).
//
// Optional feature macro: MULTDIV_TIMEOUT_EN (forces completion with an
// exception after TIMEOUT cycles in BUSY).
//
// Ports:
//   clock, reset       clock; synchronous active-low reset
//   dx_ir, dx_valid    DX instruction and its valid flag
//   mw_we/mw_rd/mw_data  MW stage write request
//   md_result/md_rdy/md_exception  mult/div unit completion
//   ctrl_mult/ctrl_div one-cycle start pulses
//   stall              freeze FD/DX
//   pw_ir              in-flight mult/div instruction (0 when none)
//   busy               scheduler not IDLE
//   wb_we/wb_rd/wb_data  register-file write port
module multdiv_wb_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir,
  input  logic        dx_valid,
  input  logic        mw_we,
  input  logic [4:0]  mw_rd,
  input  logic [31:0] mw_data,
  input  logic [31:0] md_result,
  input  logic        md_rdy,
  input  logic        md_exception,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic [31:0] pw_ir,
  output logic        busy,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {IDLE, BUSY, PEND} state_t;

  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;
  localparam logic [4:0] EXC_RD  = 5'd30;

  state_t      state;
  logic [31:0] buf_result;
  logic        buf_exc;

  // DX decode
  logic [4:0] dx_rs, dx_rt, dx_alu;
  logic       dx_is_md, dx_is_div;
  assign dx_rs     = dx_ir[21:17];
  assign dx_rt     = dx_ir[16:12];
  assign dx_alu    = dx_ir[6:2];
  assign dx_is_md  = dx_valid && (dx_ir[31:27] == 5'd0) &&
                     ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));
  assign dx_is_div = dx_alu == ALU_DIV;

  // In-flight instruction fields
  logic [4:0] pw_rd;
  logic       pw_is_div;
  assign pw_rd     = pw_ir[26:22];
  assign pw_is_div = pw_ir[6:2] == ALU_DIV;

  // Hazards only exist while an op is in flight, so the IDLE issue path never stalls.
  logic raw_hit;
  assign raw_hit = dx_valid && (pw_rd != 5'd0) && ((dx_rs == pw_rd) || (dx_rt == pw_rd));
  assign stall   = (state != IDLE) && (dx_is_md || raw_hit);
  assign busy    = state != IDLE;

  logic issue;
  assign issue     = (state == IDLE) && dx_is_md;
  assign ctrl_mult = issue && !dx_is_div;
  assign ctrl_div  = issue && dx_is_div;

  // Completion event seen in BUSY, with its exception flag
  logic md_done, md_exc;

`ifdef MULTDIV_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_hit;

  // Counter is 0 in the first BUSY cycle, so TIMEOUT-1 lands TIMEOUT cycles after issue.
  assign to_hit  = (state == BUSY) && (to_cnt == 8'(TIMEOUT - 1));
  assign md_done = (state == BUSY) && (md_rdy || to_hit);
  assign md_exc  = md_rdy ? md_exception : 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      to_cnt <= 8'd0;
    end else if (issue) begin
      to_cnt <= 8'd0;
    end else if (state == BUSY) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign md_done = (state == BUSY) && md_rdy;
  assign md_exc  = md_exception;
`endif

  logic unused_dx_bits;
  assign unused_dx_bits = ^{dx_ir[11:7], dx_ir[1:0]};

  // PW write: either straight from the unit (BUSY) or from the buffer (PEND),
  // only in a cycle where MW leaves the port free.
  logic        pw_fire, pw_exc;
  logic [31:0] pw_res, pw_tgt_data;
  logic [4:0]  pw_tgt_rd;
  assign pw_fire     = !mw_we && (md_done || (state == PEND));
  assign pw_exc      = (state == PEND) ? buf_exc : md_exc;
  assign pw_res      = (state == PEND) ? buf_result : md_result;
  assign pw_tgt_rd   = pw_exc ? EXC_RD : pw_rd;
  assign pw_tgt_data = pw_exc ? (pw_is_div ? 32'd5 : 32'd4) : pw_res;

  // wb_rd/wb_data are zeroed whenever wb_we is low (including writes to r0).
  always_comb begin
    wb_we   = mw_we;
    wb_rd   = mw_rd;
    wb_data = mw_data;
    if (pw_fire) begin
      wb_we   = pw_tgt_rd != 5'd0;
      wb_rd   = pw_tgt_rd;
      wb_data = pw_tgt_data;
    end
    if (!wb_we) begin
      wb_rd   = 5'd0;
      wb_data = 32'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      pw_ir      <= 32'd0;
      buf_result <= 32'd0;
      buf_exc    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            pw_ir <= dx_ir;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (md_done) begin
            if (mw_we) begin
              buf_result <= md_result;
              buf_exc    <= md_exc;
              state      <= PEND;
            end else begin
              pw_ir <= 32'd0;
              state <= IDLE;
            end
          end
        end
        PEND: begin
          if (!mw_we) begin
            pw_ir      <= 32'd0;
            buf_result <= 32'd0;
            buf_exc    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          pw_ir <= 32'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_wb_scheduler.sv
// tb/tb_multdiv_wb_scheduler.sv - self-checking bench for multdiv_wb_scheduler
module tb_multdiv_wb_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dx_ir;
  logic        dx_valid;
  logic        mw_we;
  logic [4:0]  mw_rd;
  logic [31:0] mw_data;
  logic [31:0] md_result;
  logic        md_rdy;
  logic        md_exception;
  logic        ctrl_mult, ctrl_div, stall, busy, wb_we;
  logic [31:0] pw_ir, wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multdiv_wb_scheduler #(.TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .dx_ir(dx_ir), .dx_valid(dx_valid),
    .mw_we(mw_we), .mw_rd(mw_rd), .mw_data(mw_data),
    .md_result(md_result), .md_rdy(md_rdy), .md_exception(md_exception),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .stall(stall),
    .pw_ir(pw_ir), .busy(busy),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct {
    logic [31:0] ir;
    logic        v, mwe;
    logic [4:0]  mrd;
    logic [31:0] mdat, res;
    logic        rdy, exc;
    logic        cm, cd, st, bs, we;
    logic [4:0]  wrd;
    logic [31:0] wdat, pir;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] alu);
    return {5'd0, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] ir, input logic v, input logic mwe, input logic [4:0] mrd,
                     input logic [31:0] mdat, input logic [31:0] res, input logic rdy, input logic exc,
                     input logic cm, input logic cd, input logic st, input logic bs, input logic we,
                     input logic [4:0] wrd, input logic [31:0] wdat, input logic [31:0] pir);
    vec_t t;
    t.ir = ir; t.v = v; t.mwe = mwe; t.mrd = mrd; t.mdat = mdat; t.res = res; t.rdy = rdy; t.exc = exc;
    t.cm = cm; t.cd = cd; t.st = st; t.bs = bs; t.we = we; t.wrd = wrd; t.wdat = wdat; t.pir = pir;
    vecs.push_back(t);
  endtask

  task automatic idle_inputs();
    dx_ir = 0; dx_valid = 0; mw_we = 0; mw_rd = 0; mw_data = 0;
    md_result = 0; md_rdy = 0; md_exception = 0;
  endtask

  logic [31:0] MUL, MUL0, DIV4, ADD, ADD2, ADDZ;
  int pulses;

  initial begin
    MUL  = rtype(5'd3, 5'd1, 5'd2, 5'd6);
    MUL0 = rtype(5'd0, 5'd1, 5'd2, 5'd6);
    DIV4 = rtype(5'd4, 5'd1, 5'd2, 5'd7);
    ADD  = rtype(5'd5, 5'd3, 5'd1, 5'd0);
    ADD2 = rtype(5'd5, 5'd1, 5'd3, 5'd0);
    ADDZ = rtype(5'd5, 5'd0, 5'd0, 5'd0);

    //   ir    v  mwe mrd mdat          res           rdy exc  cm cd st bs we wrd wdat          pir
    add(0,    0, 0,  0,  0,            0,            0,  0,   0, 0, 0, 0, 0, 0,  0,            0);    // reset state
    add(MUL,  0, 0,  0,  0,            0,            0,  0,   0, 0, 0, 0, 0, 0,  0,            0);    // invalid DX: no issue
    add(0,    0, 1,  9,  32'hAAAA,     0,            0,  0,   0, 0, 0, 0, 1, 9,  32'hAAAA,     0);    // MW passthrough
    add(DIV4, 1, 0,  0,  0,            0,            0,  0,   0, 1, 0, 0, 0, 0,  0,            0);    // div issue
    add(0,    0, 0,  0,  0,            0,            0,  0,   0, 0, 0, 1, 0, 0,  0,            DIV4);
    add(0,    0, 1,  7,  32'h77,       32'h1234,     1,  0,   0, 0, 0, 1, 1, 7,  32'h77,       DIV4); // contention -> PEND
    add(0,    0, 1,  7,  32'h77,       32'hDEAD,     1,  1,   0, 0, 0, 1, 1, 7,  32'h77,       DIV4); // stray rdy ignored
    add(0,    0, 1,  7,  32'h77,       0,            0,  0,   0, 0, 0, 1, 1, 7,  32'h77,       DIV4);
    add(0,    0, 0,  0,  0,            0,            0,  0,   0, 0, 0, 1, 1, 4,  32'h1234,     DIV4); // buffered write
    add(0,    0, 0,  0,  0,            32'h5,        1,  0,   0, 0, 0, 0, 0, 0,  0,            0);    // rdy in IDLE ignored
    add(MUL,  1, 0,  0,  0,            0,            0,  0,   1, 0, 0, 0, 0, 0,  0,            0);    // mul issue
    add(DIV4, 1, 0,  0,  0,            0,            0,  0,   0, 0, 1, 1, 0, 0,  0,            MUL);  // structural stall
    add(DIV4, 1, 0,  0,  0,            32'd42,       1,  0,   0, 0, 1, 1, 1, 3,  32'd42,       MUL);  // rdy + mult/div in DX
    add(DIV4, 1, 0,  0,  0,            0,            0,  0,   0, 1, 0, 0, 0, 0,  0,            0);    // div issues next cycle
    add(0,    0, 0,  0,  0,            0,            0,  0,   0, 0, 0, 1, 0, 0,  0,            DIV4);
    add(0,    0, 0,  0,  0,            32'd99,       1,  1,   0, 0, 0, 1, 1, 30, 32'd5,        DIV4); // div exception
    add(0,    0, 0,  0,  0,            0,            0,  0,   0, 0, 0, 0, 0, 0,  0,            0);
    add(MUL,  1, 0,  0,  0,            0,            0,  0,   1, 0, 0, 0, 0, 0,  0,            0);
    add(ADD2, 1, 0,  0,  0,            0,            0,  0,   0, 0, 1, 1, 0, 0,  0,            MUL);  // RAW on rt
    add(ADD,  1, 0,  0,  0,            32'd7,        1,  0,   0, 0, 1, 1, 1, 3,  32'd7,        MUL);  // RAW on rs
    add(ADD,  1, 0,  0,  0,            0,            0,  0,   0, 0, 0, 0, 0, 0,  0,            0);    // released
    add(MUL0, 1, 0,  0,  0,            0,            0,  0,   1, 0, 0, 0, 0, 0,  0,            0);
    add(ADDZ, 1, 0,  0,  0,            0,            0,  0,   0, 0, 0, 1, 0, 0,  0,            MUL0); // r0 never hazards
    add(ADD,  1, 0,  0,  0,            32'd11,       1,  0,   0, 0, 0, 1, 0, 0,  0,            MUL0); // r0 write suppressed
    add(0,    0, 0,  0,  0,            0,            0,  0,   0, 0, 0, 0, 0, 0,  0,            0);
    add(MUL,  1, 0,  0,  0,            0,            0,  0,   1, 0, 0, 0, 0, 0,  0,            0);
    add(ADD,  0, 0,  0,  0,            0,            0,  0,   0, 0, 0, 1, 0, 0,  0,            MUL);  // invalid DX: no RAW
    add(0,    0, 1,  12, 32'hBEEF,     32'd1,        1,  1,   0, 0, 0, 1, 1, 12, 32'hBEEF,     MUL);  // exc under contention
    add(0,    0, 0,  0,  0,            0,            0,  0,   0, 0, 0, 1, 1, 30, 32'd4,        MUL);  // buffered mul exc
    add(0,    0, 0,  0,  0,            0,            0,  0,   0, 0, 0, 0, 0, 0,  0,            0);

    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      dx_ir = vecs[i].ir; dx_valid = vecs[i].v;
      mw_we = vecs[i].mwe; mw_rd = vecs[i].mrd; mw_data = vecs[i].mdat;
      md_result = vecs[i].res; md_rdy = vecs[i].rdy; md_exception = vecs[i].exc;
      #1;
      chk($sformatf("row%0d.ctrl_mult", i), 32'(ctrl_mult), 32'(vecs[i].cm));
      chk($sformatf("row%0d.ctrl_div", i),  32'(ctrl_div),  32'(vecs[i].cd));
      chk($sformatf("row%0d.stall", i),     32'(stall),     32'(vecs[i].st));
      chk($sformatf("row%0d.busy", i),      32'(busy),      32'(vecs[i].bs));
      chk($sformatf("row%0d.wb_we", i),     32'(wb_we),     32'(vecs[i].we));
      chk($sformatf("row%0d.wb_rd", i),     32'(wb_rd),     32'(vecs[i].wrd));
      chk($sformatf("row%0d.wb_data", i),   wb_data,        vecs[i].wdat);
      chk($sformatf("row%0d.pw_ir", i),     pw_ir,          vecs[i].pir);
      @(negedge clock);
    end

    // mul r3 with result 32 cycles after issue, MW idle
    idle_inputs();
    dx_ir = MUL; dx_valid = 1;
    #1;
    pulses = int'(ctrl_mult);
    chk("long.issue_pulse", 32'(ctrl_mult), 32'd1);
    @(negedge clock);
    dx_ir = 0; dx_valid = 0;
    for (int k = 1; k < 32; k++) begin
      #1;
      pulses += int'(ctrl_mult);
      if (k == 1) chk("long.busy", 32'(busy), 32'd1);
      if (k == 1) chk("long.pw_ir", pw_ir, MUL);
      @(negedge clock);
    end
    md_rdy = 1; md_result = 32'h00C0FFEE;
    #1;
    chk("long.wb_we", 32'(wb_we), 32'd1);
    chk("long.wb_rd", 32'(wb_rd), 32'd3);
    chk("long.wb_data", wb_data, 32'h00C0FFEE);
    chk("long.busy_at_rdy", 32'(busy), 32'd1);
    @(negedge clock);
    md_rdy = 0; md_result = 0;
    #1;
    chk("long.busy_after", 32'(busy), 32'd0);
    chk("long.pulse_count", 32'(pulses), 32'd1);
    @(negedge clock);

    // reset mid-BUSY, then a stray md_rdy
    dx_ir = DIV4; dx_valid = 1;
    #1;
    chk("rst.issue", 32'(ctrl_div), 32'd1);
    @(negedge clock);
    dx_ir = 0; dx_valid = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    md_rdy = 1; md_result = 32'h55;
    #1;
    chk("rst.wb_we", 32'(wb_we), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.pw_ir", pw_ir, 32'd0);
    @(negedge clock);
    md_rdy = 0;
    #1;
    chk("rst.busy_later", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
